// File: rtl/ifq_pkg.sv
// ifq_pkg: shared state encoding and default parameters for the instruction fetch queue
package ifq_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} ifq_state_t;
    localparam int          DEF_DEPTH    = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: synchronous circular FIFO with flush and occupancy count
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
    // Pointers and occupancy; flush empties the queue ahead of any push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wr <= r_wr + AW'(1);
            if (i_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    // Entry storage; left unreset because the count qualifies every read
    always_ff @(posedge clk) begin
        if (i_push && !i_flush)
            r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch unit feeding a small instruction queue; define IFQ_BYPASS_EN to hand a response to the core in its arrival cycle
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = DEF_DEPTH,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    ifq_state_t    r_state;
    ifq_state_t    w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_pend_pc;
    logic [CW-1:0] w_count;
    logic [63:0]   w_head;
    logic          w_req_fire;
    logic          w_resp_ok;
    logic          w_head_valid;
    logic          w_push;
    logic          w_pop;
    assign w_head_valid = w_count != '0;
    assign w_resp_ok    = (r_state == WAIT) && mem_resp_valid && !redirect;
    assign w_pop        = w_head_valid && instr_ready && !redirect;
    assign w_req_fire   = mem_req_valid && mem_req_ready;
    assign mem_req_addr = r_fetch_pc;
`ifdef IFQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass    = w_resp_ok && !w_head_valid;
    assign instr_valid = w_head_valid || w_bypass;
    assign instr       = w_head_valid ? w_head[31:0] : w_bypass ? mem_resp_data : '0;
    assign instr_pc    = w_head_valid ? w_head[63:32] : w_bypass ? r_pend_pc : '0;
    assign w_push      = w_resp_ok && !(w_bypass && instr_ready);
`else
    assign instr_valid = w_head_valid;
    assign instr       = w_head_valid ? w_head[31:0] : '0;
    assign instr_pc    = w_head_valid ? w_head[63:32] : '0;
    assign w_push      = w_resp_ok;
`endif
    // Request only with nothing in flight, no redirect and a free slot; a redirect turns an in-flight fetch stale
    always_comb begin
        w_state_nxt   = r_state;
        mem_req_valid = !rst && (r_state == IDLE) && !redirect && (w_count < CW'(DEPTH));
        case (r_state)
            IDLE:    w_state_nxt = (mem_req_valid && mem_req_ready) ? WAIT : IDLE;
            WAIT:    w_state_nxt = mem_resp_valid ? IDLE : redirect ? DISCARD : WAIT;
            DISCARD: w_state_nxt = mem_resp_valid ? IDLE : DISCARD;
            default: w_state_nxt = IDLE;
        endcase
    end
    // Fetch state, next fetch address and the address of the fetch in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= redirect ? (redirect_pc & ~32'h3) : w_req_fire ? r_fetch_pc + 32'd4 : r_fetch_pc;
            if (w_req_fire)
                r_pend_pc <= r_fetch_pc;
        end
    end
    ifq_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_pend_pc, mem_resp_data}),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_data  (w_head),
        .o_count (w_count)
    );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: table vectors, corner sequences and a randomized run against a queue-based model
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
`ifdef IFQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        redir;
        logic [31:0] rpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        instr_valid;
    logic [31:0] mem_req_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    int n_chk = 0;
    int n_pass = 0;
    vec_t tv [18];
    logic [31:0] m_q [$];
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_pend;
    logic [31:0] m_fpc;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic ir, input logic redir, input logic [31:0] rpc);
        mem_req_ready  = rdy;
        mem_resp_valid = rv;
        mem_resp_data  = rd;
        instr_ready    = ir;
        redirect       = redir;
        redirect_pc    = rpc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive(T, F, '0, F, F, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_valid", mem_req_valid, 0);
        chk("reset instr_valid", instr_valid, 0);
        chk("reset instr", instr, 0);
        chk("reset instr_pc", instr_pc, 0);
        chk("reset req_addr", mem_req_addr, RPC);
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int fires;
        logic p;
        logic [31:0] paddr;
        tv[0]  = '{T, F, '0,                    T, F, '0,           T, 32'h3000, F,   '0};
        tv[1]  = '{T, T, mem_word(32'h3000),    F, F, '0,           F, '0,       BYP, 32'h3000};
        tv[2]  = '{T, F, '0,                    T, F, '0,           T, 32'h3004, T,   32'h3000};
        tv[3]  = '{T, T, mem_word(32'h3004),    F, F, '0,           F, '0,       BYP, 32'h3004};
        tv[4]  = '{T, F, '0,                    T, F, '0,           T, 32'h3008, T,   32'h3004};
        tv[5]  = '{T, T, mem_word(32'h3008),    F, F, '0,           F, '0,       BYP, 32'h3008};
        tv[6]  = '{F, F, '0,                    T, F, '0,           T, 32'h300C, T,   32'h3008};
        tv[7]  = '{T, F, '0,                    T, F, '0,           T, 32'h300C, F,   '0};
        tv[8]  = '{F, F, '0,                    T, T, 32'h4001,     F, '0,       F,   '0};
        tv[9]  = '{T, T, mem_word(32'h300C),    T, F, '0,           F, '0,       F,   '0};
        tv[10] = '{T, F, '0,                    T, F, '0,           T, 32'h4000, F,   '0};
        tv[11] = '{T, T, mem_word(32'h4000),    F, F, '0,           F, '0,       BYP, 32'h4000};
        tv[12] = '{T, F, '0,                    F, F, '0,           T, 32'h4004, T,   32'h4000};
        tv[13] = '{T, T, mem_word(32'h4004),    T, T, 32'h5000,     F, '0,       T,   32'h4000};
        tv[14] = '{F, T, 32'hDEAD_BEEF,         T, F, '0,           T, 32'h5000, F,   '0};
        tv[15] = '{T, F, '0,                    T, F, '0,           T, 32'h5000, F,   '0};
        tv[16] = '{T, T, mem_word(32'h5000),    F, F, '0,           F, '0,       BYP, 32'h5000};
        tv[17] = '{F, F, '0,                    T, F, '0,           T, 32'h5004, T,   32'h5000};

        reset_dut();
        for (int i = 0; i < 18; i++) begin
            drive(tv[i].rdy, tv[i].rv, tv[i].rd, tv[i].ir, tv[i].redir, tv[i].rpc);
            @(negedge clk);
            chk($sformatf("vec%0d req_valid", i), mem_req_valid, tv[i].e_rv);
            if (tv[i].e_rv)
                chk($sformatf("vec%0d req_addr", i), mem_req_addr, tv[i].e_addr);
            chk($sformatf("vec%0d instr_valid", i), instr_valid, tv[i].e_iv);
            if (tv[i].e_iv) begin
                chk($sformatf("vec%0d instr_pc", i), instr_pc, tv[i].e_pc);
                chk($sformatf("vec%0d instr", i), instr, mem_word(tv[i].e_pc));
            end
            next_cycle();
        end

        reset_dut();
        fires = 0;
        p = 1'b0;
        paddr = '0;
        for (int c = 0; c < 20; c++) begin
            drive(T, p, mem_word(paddr), F, F, '0);
            @(negedge clk);
            p = mem_req_valid && mem_req_ready;
            if (p) begin
                fires++;
                paddr = mem_req_addr;
            end
            next_cycle();
        end
        chk("full request count", fires, DEPTH);
        drive(F, F, '0, T, F, '0);
        @(negedge clk);
        chk("full req_valid held low", mem_req_valid, 0);
        chk("full head pc", instr_pc, RPC);
        next_cycle();
        drive(F, F, '0, F, F, '0);
        @(negedge clk);
        chk("after pop req_valid", mem_req_valid, 1);
        chk("after pop req_addr", mem_req_addr, 32'h3010);
        next_cycle();

        drive(F, F, '0, F, T, 32'hFFFF_FFFE);
        next_cycle();
        drive(T, F, '0, F, F, '0);
        @(negedge clk);
        chk("wrap req_addr top", mem_req_addr, 32'hFFFF_FFFC);
        chk("wrap flushed", instr_valid, 0);
        next_cycle();
        drive(T, T, mem_word(32'hFFFF_FFFC), F, F, '0);
        @(negedge clk);
        chk("wrap resp cycle valid", instr_valid, BYP);
        next_cycle();
        drive(F, F, '0, T, F, '0);
        @(negedge clk);
        chk("wrap req_valid", mem_req_valid, 1);
        chk("wrap req_addr zero", mem_req_addr, 32'h0);
        chk("wrap instr_pc", instr_pc, 32'hFFFF_FFFC);
        next_cycle();

        drive(T, F, '0, T, F, '0);
        @(negedge clk);
        chk("bypass req_addr", mem_req_addr, 32'h0);
        next_cycle();
        drive(F, T, mem_word(32'h0), T, F, '0);
        @(negedge clk);
        chk("bypass same-cycle valid", instr_valid, BYP);
        next_cycle();
        drive(F, F, '0, T, F, '0);
        @(negedge clk);
        chk("bypass next-cycle valid", instr_valid, !BYP);
        next_cycle();
        drive(F, F, '0, F, F, '0);
        @(negedge clk);
        chk("bypass drained", instr_valid, 0);
        next_cycle();

        reset_dut();
        m_q.delete();
        m_out = 1'b0;
        m_stale = 1'b0;
        m_pend = '0;
        m_fpc = RPC;
        for (int c = 0; c < 3000; c++) begin
            logic rdy, rv, ir, redir, e_rv, e_byp, e_iv;
            logic [31:0] rd, rpc, e_pc;
            rdy = $urandom_range(0, 3) != 0;
            ir = $urandom_range(0, 2) != 0;
            redir = $urandom_range(0, 15) == 0;
            rpc = $urandom;
            if ($urandom_range(0, 7) == 0)
                rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:0]};
            rv = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            rd = m_out ? mem_word(m_pend) : $urandom;
            drive(rdy, rv, rd, ir, redir, rpc);
            e_rv = !m_out && !redir && (m_q.size() < DEPTH);
            e_byp = BYP && m_out && !m_stale && rv && !redir && (m_q.size() == 0);
            e_iv = (m_q.size() > 0) || e_byp;
            e_pc = (m_q.size() > 0) ? m_q[0] : m_pend;
            @(negedge clk);
            chk($sformatf("rnd%0d req_valid", c), mem_req_valid, e_rv);
            if (e_rv)
                chk($sformatf("rnd%0d req_addr", c), mem_req_addr, m_fpc);
            chk($sformatf("rnd%0d instr_valid", c), instr_valid, e_iv);
            if (e_iv) begin
                chk($sformatf("rnd%0d instr_pc", c), instr_pc, e_pc);
                chk($sformatf("rnd%0d instr", c), instr, mem_word(e_pc));
            end
            if (redir) begin
                m_q.delete();
                m_fpc = rpc & ~32'h3;
                if (m_out && rv) begin
                    m_out = 1'b0;
                    m_stale = 1'b0;
                end else if (m_out)
                    m_stale = 1'b1;
            end else begin
                if (ir && m_q.size() > 0)
                    void'(m_q.pop_front());
                if (m_out && rv) begin
                    if (!m_stale && !(e_byp && ir))
                        m_q.push_back(m_pend);
                    m_out = 1'b0;
                    m_stale = 1'b0;
                end
                if (e_rv && rdy) begin
                    m_out = 1'b1;
                    m_pend = m_fpc;
                    m_fpc = m_fpc + 32'd4;
                end
            end
            next_cycle();
        end

        reset_dut();
        drive(T, F, '0, F, F, '0);
        @(negedge clk);
        chk("midreset first req", mem_req_addr, RPC);
        next_cycle();
        drive(F, F, '0, F, F, '0);
        rst = 1'b1;
        #1;
        chk("midreset req_valid", mem_req_valid, 0);
        chk("midreset instr_valid", instr_valid, 0);
        chk("midreset req_addr", mem_req_addr, RPC);
        next_cycle();
        rst = 1'b0;
        drive(F, T, 32'h1234_5678, T, F, '0);
        @(negedge clk);
        chk("post reset req_valid", mem_req_valid, 1);
        chk("post reset req_addr", mem_req_addr, RPC);
        chk("post reset instr_valid", instr_valid, 0);
        next_cycle();
        drive(F, F, '0, T, F, '0);
        @(negedge clk);
        chk("stale resp ignored", instr_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
